// File: rtl/rv64_trap_ctrl_pkg.sv
// Shared encodings for the machine-mode trap/return sequencer:
// request kinds, cause codes, mstatus bit positions and FSM states.
package rv64_trap_ctrl_pkg;

  localparam logic [2:0] TRAP_ECALL   = 3'd0;
  localparam logic [2:0] TRAP_EBREAK  = 3'd1;
  localparam logic [2:0] TRAP_ILLEGAL = 3'd2;
  localparam logic [2:0] TRAP_MRET    = 3'd3;

  localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK    = 4'd3;
  localparam logic [3:0] CAUSE_IRQ_TIMER = 4'd7;
  localparam logic [3:0] CAUSE_ECALL     = 4'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SAVE  = 2'd1,
    ST_UPD   = 2'd2,
    ST_REDIR = 2'd3
  } state_e;

endpackage

// File: rtl/rv64_trap_ctrl_target.sv
// Combinational redirect target: mepc for mret, otherwise the mtvec base,
// offset by 4*cause only for a vectored-mode interrupt.
module rv64_trap_ctrl_target #(
  parameter int XLEN        = 64,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic [XLEN-1:0] mtvec,
  input  logic [3:0]      cause,
  input  logic            is_irq,
  input  logic            is_mret,
  input  logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] base_s;
  logic [XLEN-1:0] offset_s;
  logic            vectored_s;

  // MODE 2/3 fall back to direct; only MODE 1 with an interrupt is vectored
  always_comb begin
    base_s     = {mtvec[XLEN-1:2], 2'b00};
    vectored_s = (VECTORED_EN == 1'b1) && is_irq && (mtvec[1:0] == 2'b01);
    if (vectored_s) begin
      offset_s = {{(XLEN-6){1'b0}}, cause, 2'b00};
    end else begin
      offset_s = '0;
    end
    if (is_mret) begin
      target = mepc;
    end else begin
      target = base_s + offset_s;
    end
  end

endmodule

// File: rtl/rv64_trap_ctrl.sv
// Trap/return sequencer: drives the dedicated mstatus/mepc/mcause/mtval write
// ports over SAVE/UPD, then holds a PC redirect until IFU accepts it.
module rv64_trap_ctrl
  import rv64_trap_ctrl_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter bit VECTORED_EN = 1'b1,
  parameter bit IRQ_EN      = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid,
  output logic            trap_ready,
  input  logic [2:0]      trap_kind,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [31:0]     trap_inst,
  input  logic            irq_timer_i,
  input  logic [XLEN-1:0] mstatus_q,
  input  logic [XLEN-1:0] mepc_q,
  input  logic [XLEN-1:0] mtvec_q,
  output logic [XLEN-1:0] csr_mstatus_i,
  output logic            csr_mstatus_i_en,
  output logic [XLEN-1:0] csr_mepc_i,
  output logic            csr_mepc_i_en,
  output logic [XLEN-1:0] csr_mcause_i,
  output logic            csr_mcause_i_en,
  output logic [XLEN-1:0] csr_mtval_i,
  output logic            csr_mtval_i_en,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            busy
);

  state_e          state_r;
  logic            irq_pend_r, is_irq_r, is_mret_r;
  logic [3:0]      cause_r;
  logic            trap_ready_r, busy_r, redirect_valid_r;
  logic [XLEN-1:0] redirect_pc_r;
  logic [XLEN-1:0] mstatus_r, mepc_r, mcause_r, mtval_r;
  logic            mstatus_en_r, mepc_en_r, mcause_en_r, mtval_en_r;

  logic            accept_s, take_irq_s, req_mret_s;
  logic [3:0]      req_cause_s;
  logic [XLEN-1:0] req_mtval_s, mstatus_trap_s, mstatus_mret_s, target_s;

  rv64_trap_ctrl_target #(.XLEN(XLEN), .VECTORED_EN(VECTORED_EN)) u_target (
    .mtvec   (mtvec_q),
    .cause   (cause_r),
    .is_irq  (is_irq_r),
    .is_mret (is_mret_r),
    .mepc    (mepc_q),
    .target  (target_s)
  );

  // Request arbitration, cause/mtval decode and next-mstatus images
  always_comb begin
    accept_s   = (state_r == ST_IDLE) && trap_ready_r && trap_valid;
    take_irq_s = (state_r == ST_IDLE) && trap_ready_r && !trap_valid &&
                 irq_pend_r && mstatus_q[MSTATUS_MIE];
    req_mret_s  = 1'b0;
    req_cause_s = CAUSE_ILLEGAL;
    req_mtval_s = {{(XLEN-32){1'b0}}, trap_inst};
    case (trap_kind)
      TRAP_ECALL:   begin req_cause_s = CAUSE_ECALL;  req_mtval_s = '0;      end
      TRAP_EBREAK:  begin req_cause_s = CAUSE_EBREAK; req_mtval_s = trap_pc; end
      TRAP_ILLEGAL: begin req_cause_s = CAUSE_ILLEGAL; end
      TRAP_MRET:    begin req_mret_s = 1'b1; req_mtval_s = '0; end
      default:      begin req_cause_s = CAUSE_ILLEGAL; end
    endcase
    mstatus_trap_s = mstatus_q;
    mstatus_trap_s[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
    mstatus_trap_s[MSTATUS_MIE]  = 1'b0;
    mstatus_trap_s[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO] = 2'b11;
    mstatus_mret_s = mstatus_q;
    mstatus_mret_s[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
    mstatus_mret_s[MSTATUS_MPIE] = 1'b1;
    mstatus_mret_s[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO] = 2'b11;
  end

  // Timer interrupt pending latch; a held level re-arms it after entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_pend_r <= 1'b0;
    end else begin
      irq_pend_r <= (irq_pend_r && !take_irq_s) || (irq_timer_i && IRQ_EN);
    end
  end

  // Sequencer FSM with registered CSR write ports and redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r          <= ST_IDLE;
      is_irq_r         <= 1'b0;
      is_mret_r        <= 1'b0;
      cause_r          <= 4'd0;
      trap_ready_r     <= 1'b0;
      busy_r           <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= '0;
      mstatus_r <= '0; mepc_r <= '0; mcause_r <= '0; mtval_r <= '0;
      mstatus_en_r <= 1'b0; mepc_en_r <= 1'b0; mcause_en_r <= 1'b0; mtval_en_r <= 1'b0;
    end else begin
      mstatus_r <= '0; mepc_r <= '0; mcause_r <= '0; mtval_r <= '0;
      mstatus_en_r <= 1'b0; mepc_en_r <= 1'b0; mcause_en_r <= 1'b0; mtval_en_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          trap_ready_r <= 1'b1;
          busy_r       <= 1'b0;
          if (accept_s) begin
            trap_ready_r <= 1'b0;
            busy_r       <= 1'b1;
            is_irq_r     <= 1'b0;
            is_mret_r    <= req_mret_s;
            cause_r      <= req_cause_s;
            if (req_mret_s) begin
              state_r      <= ST_UPD;
              mstatus_en_r <= 1'b1;
              mstatus_r    <= mstatus_mret_s;
            end else begin
              state_r     <= ST_SAVE;
              mepc_en_r   <= 1'b1;
              mcause_en_r <= 1'b1;
              mtval_en_r  <= 1'b1;
              mepc_r      <= {trap_pc[XLEN-1:2], 2'b00};
              mcause_r    <= {{(XLEN-4){1'b0}}, req_cause_s};
              mtval_r     <= req_mtval_s;
            end
          end else if (take_irq_s) begin
            state_r      <= ST_SAVE;
            trap_ready_r <= 1'b0;
            busy_r       <= 1'b1;
            is_irq_r     <= 1'b1;
            is_mret_r    <= 1'b0;
            cause_r      <= CAUSE_IRQ_TIMER;
            mepc_en_r    <= 1'b1;
            mcause_en_r  <= 1'b1;
            mtval_en_r   <= 1'b1;
            mepc_r       <= {trap_pc[XLEN-1:2], 2'b00};
            mcause_r     <= {1'b1, {(XLEN-5){1'b0}}, CAUSE_IRQ_TIMER};
            mtval_r      <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SAVE: begin
          state_r      <= ST_UPD;
          mstatus_en_r <= 1'b1;
          mstatus_r    <= mstatus_trap_s;
        end
        ST_UPD: begin
          state_r          <= ST_REDIR;
          redirect_valid_r <= 1'b1;
          redirect_pc_r    <= target_s;
        end
        ST_REDIR: begin
          if (redirect_ready) begin
            state_r          <= ST_IDLE;
            redirect_valid_r <= 1'b0;
            trap_ready_r     <= 1'b1;
            busy_r           <= 1'b0;
          end else begin
            state_r <= ST_REDIR;
          end
        end
        default: begin
          state_r          <= ST_IDLE;
          trap_ready_r     <= 1'b0;
          busy_r           <= 1'b0;
          redirect_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign trap_ready       = trap_ready_r;
  assign busy             = busy_r;
  assign redirect_valid   = redirect_valid_r;
  assign redirect_pc      = redirect_pc_r;
  assign flush            = redirect_valid_r & redirect_ready;
  assign csr_mstatus_i    = mstatus_r;
  assign csr_mstatus_i_en = mstatus_en_r;
  assign csr_mepc_i       = mepc_r;
  assign csr_mepc_i_en    = mepc_en_r;
  assign csr_mcause_i     = mcause_r;
  assign csr_mcause_i_en  = mcause_en_r;
  assign csr_mtval_i      = mtval_r;
  assign csr_mtval_i_en   = mtval_en_r;

endmodule

// File: tb/tb_rv64_trap_ctrl.sv
// Scoreboard bench for rv64_trap_ctrl: expected CSR writes and redirects are
// queued at stimulus time and compared as the DUTs (vectored and direct) emit them.
module tb_rv64_trap_ctrl;
  import rv64_trap_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trap_valid = 1'b0;
  logic [2:0]  trap_kind = 3'd0;
  logic [63:0] trap_pc = 64'd0;
  logic [31:0] trap_inst = 32'd0;
  logic        irq_timer_i = 1'b0;
  logic [63:0] mstatus_q = 64'd0, mepc_q = 64'd0, mtvec_q = 64'd0;
  logic        redirect_ready = 1'b1;

  logic        trap_ready, redirect_valid, flush, busy;
  logic [63:0] redirect_pc, csr_mstatus_i, csr_mepc_i, csr_mcause_i, csr_mtval_i;
  logic        csr_mstatus_i_en, csr_mepc_i_en, csr_mcause_i_en, csr_mtval_i_en;

  logic        trap_ready_b, redirect_valid_b, flush_b, busy_b;
  logic [63:0] redirect_pc_b, mstatus_b, mepc_b, mcause_b, mtval_b;
  logic        mstatus_en_b, mepc_en_b, mcause_en_b, mtval_en_b;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] q_mepc[$], q_mcause[$], q_mtval[$], q_mstatus[$], q_redir[$], q_redir_b[$];

  localparam logic [63:0] IRQ_CAUSE = 64'h8000_0000_0000_0007;

  always #5 clk = ~clk;

  rv64_trap_ctrl #(.XLEN(64), .VECTORED_EN(1'b1), .IRQ_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .trap_valid(trap_valid), .trap_ready(trap_ready),
    .trap_kind(trap_kind), .trap_pc(trap_pc), .trap_inst(trap_inst),
    .irq_timer_i(irq_timer_i), .mstatus_q(mstatus_q), .mepc_q(mepc_q), .mtvec_q(mtvec_q),
    .csr_mstatus_i(csr_mstatus_i), .csr_mstatus_i_en(csr_mstatus_i_en),
    .csr_mepc_i(csr_mepc_i), .csr_mepc_i_en(csr_mepc_i_en),
    .csr_mcause_i(csr_mcause_i), .csr_mcause_i_en(csr_mcause_i_en),
    .csr_mtval_i(csr_mtval_i), .csr_mtval_i_en(csr_mtval_i_en),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush(flush), .busy(busy)
  );

  rv64_trap_ctrl #(.XLEN(64), .VECTORED_EN(1'b0), .IRQ_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .trap_valid(trap_valid), .trap_ready(trap_ready_b),
    .trap_kind(trap_kind), .trap_pc(trap_pc), .trap_inst(trap_inst),
    .irq_timer_i(irq_timer_i), .mstatus_q(mstatus_q), .mepc_q(mepc_q), .mtvec_q(mtvec_q),
    .csr_mstatus_i(mstatus_b), .csr_mstatus_i_en(mstatus_en_b),
    .csr_mepc_i(mepc_b), .csr_mepc_i_en(mepc_en_b),
    .csr_mcause_i(mcause_b), .csr_mcause_i_en(mcause_en_b),
    .csr_mtval_i(mtval_b), .csr_mtval_i_en(mtval_en_b),
    .redirect_valid(redirect_valid_b), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc_b), .flush(flush_b), .busy(busy_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  task automatic push_trap(input logic [63:0] mepc, input logic [63:0] mcause,
                           input logic [63:0] mtval, input logic [63:0] mstatus,
                           input logic [63:0] redir, input logic [63:0] redir_b);
    q_mepc.push_back(mepc);
    q_mcause.push_back(mcause);
    q_mtval.push_back(mtval);
    q_mstatus.push_back(mstatus);
    q_redir.push_back(redir);
    q_redir_b.push_back(redir_b);
  endtask

  // Monitor: every CSR write or redirect handshake must match the next queued expectation
  always @(negedge clk) begin
    if (rst) begin
      if (csr_mepc_i_en) begin
        if (q_mepc.size() == 0) check_eq("mepc_unexpected", 64'd1, 64'd0);
        else check_eq("mepc", csr_mepc_i, q_mepc.pop_front());
      end
      if (csr_mcause_i_en) begin
        if (q_mcause.size() == 0) check_eq("mcause_unexpected", 64'd1, 64'd0);
        else check_eq("mcause", csr_mcause_i, q_mcause.pop_front());
      end
      if (csr_mtval_i_en) begin
        if (q_mtval.size() == 0) check_eq("mtval_unexpected", 64'd1, 64'd0);
        else check_eq("mtval", csr_mtval_i, q_mtval.pop_front());
      end
      if (csr_mstatus_i_en) begin
        if (q_mstatus.size() == 0) check_eq("mstatus_unexpected", 64'd1, 64'd0);
        else check_eq("mstatus", csr_mstatus_i, q_mstatus.pop_front());
      end
      if (redirect_valid && redirect_ready) begin
        check_eq("flush", 64'(flush), 64'd1);
        if (q_redir.size() == 0) check_eq("redir_unexpected", 64'd1, 64'd0);
        else begin
          check_eq("redirect_pc", redirect_pc, q_redir.pop_front());
          check_eq("redirect_pc_direct", redirect_pc_b, q_redir_b.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [2:0] kind, input logic [63:0] pc,
                      input logic [31:0] inst, input int exp_lat);
    int n;
    n = 0;
    while (!trap_ready && n < 50) begin @(posedge clk); #1; n++; end
    check_eq("ready_timeout", 64'(n < 50), 64'd1);
    trap_valid = 1'b1; trap_kind = kind; trap_pc = pc; trap_inst = inst;
    @(posedge clk); #1;
    trap_valid = 1'b0;
    n = 1;
    while (!redirect_valid && n < 20) begin @(posedge clk); #1; n++; end
    check_eq("latency", 64'(n), 64'(exp_lat));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(q_redir.size() == 0 && trap_ready && !busy) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check_eq("drain_timeout", 64'(n < 200), 64'd1);
  endtask

  task automatic irq_pulse();
    @(posedge clk); #1; irq_timer_i = 1'b1;
    @(posedge clk); #1; irq_timer_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check_eq("rst_ctrl", 64'({trap_ready, busy, redirect_valid, flush, csr_mstatus_i_en,
              csr_mepc_i_en, csr_mcause_i_en, csr_mtval_i_en}), 64'd0);
    check_eq("rst_data", csr_mstatus_i | csr_mepc_i | csr_mcause_i | csr_mtval_i | redirect_pc, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mtvec_q = 64'h8000_1000; mstatus_q = 64'h8;

    // ecall, then ebreak with an unaligned pc
    push_trap(64'h8000_0104, 64'd11, 64'd0, 64'h1880, 64'h8000_1000, 64'h8000_1000);
    send(TRAP_ECALL, 64'h8000_0104, 32'h0000_0073, 3);
    wait_drain();
    push_trap(64'h8000_0104, 64'd3, 64'h8000_0106, 64'h1880, 64'h8000_1000, 64'h8000_1000);
    send(TRAP_EBREAK, 64'h8000_0106, 32'h0010_0073, 3);
    wait_drain();

    // illegal with IFU back-pressure
    redirect_ready = 1'b0;
    push_trap(64'h8000_0108, 64'd2, 64'h0000_0000_FFFF_FFFF, 64'h1880, 64'h8000_1000, 64'h8000_1000);
    send(TRAP_ILLEGAL, 64'h8000_0108, 32'hFFFF_FFFF, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 64'(redirect_valid), 64'd1);
      check_eq("hold_pc", redirect_pc, 64'h8000_1000);
      check_eq("hold_flush", 64'(flush), 64'd0);
      check_eq("hold_ready", 64'(trap_ready), 64'd0);
    end
    @(posedge clk); #1 redirect_ready = 1'b1;
    wait_drain();

    // mret: only mstatus written
    mepc_q = 64'h8000_0200; mstatus_q = 64'h1880;
    q_mstatus.push_back(64'h1888);
    q_redir.push_back(64'h8000_0200);
    q_redir_b.push_back(64'h8000_0200);
    send(TRAP_MRET, 64'h8000_0300, 32'h3020_0073, 2);
    wait_drain();
    mstatus_q = 64'h8;

    // timer irq: vectored, then MODE 3 treated as direct
    trap_pc = 64'h8000_0300;
    mtvec_q = 64'h8000_1001;
    push_trap(64'h8000_0300, IRQ_CAUSE, 64'd0, 64'h1880, 64'h8000_101C, 64'h8000_1000);
    irq_pulse();
    wait_drain();
    mtvec_q = 64'h8000_1003;
    push_trap(64'h8000_0300, IRQ_CAUSE, 64'd0, 64'h1880, 64'h8000_1000, 64'h8000_1000);
    irq_pulse();
    wait_drain();

    // irq held off by MIE=0, taken once MIE is set
    mtvec_q = 64'h8000_1001; mstatus_q = 64'h0;
    irq_pulse();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("masked_busy", 64'(busy), 64'd0);
    end
    push_trap(64'h8000_0300, IRQ_CAUSE, 64'd0, 64'h1880, 64'h8000_101C, 64'h8000_1000);
    @(posedge clk); #1 mstatus_q = 64'h8;
    @(posedge clk); @(negedge clk);
    check_eq("unmask_entry_busy", 64'(busy), 64'd1);
    wait_drain();

    // trap and pending irq in the same cycle: trap first, irq right after
    push_trap(64'h8000_0400, 64'd11, 64'd0, 64'h1880, 64'h8000_1000, 64'h8000_1000);
    push_trap(64'h8000_0400, IRQ_CAUSE, 64'd0, 64'h1880, 64'h8000_101C, 64'h8000_1000);
    @(posedge clk); #1 irq_timer_i = 1'b1;
    @(posedge clk); #1 irq_timer_i = 1'b0;
    trap_valid = 1'b1; trap_kind = TRAP_ECALL; trap_pc = 64'h8000_0400;
    @(posedge clk); #1 trap_valid = 1'b0;
    wait_drain();

    // reset asserted during UPD
    mtvec_q = 64'h8000_1000;
    q_mepc.push_back(64'h8000_0500);
    q_mcause.push_back(64'd11);
    q_mtval.push_back(64'd0);
    trap_valid = 1'b1; trap_kind = TRAP_ECALL; trap_pc = 64'h8000_0500;
    @(posedge clk); #1 trap_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check_eq("midrst_ctrl", 64'({trap_ready, busy, redirect_valid, flush, csr_mstatus_i_en}), 64'd0);
    check_eq("midrst_data", csr_mstatus_i | redirect_pc, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_ready", 64'(trap_ready), 64'd1);
    repeat (4) @(negedge clk);
    check_eq("post_rst_idle", 64'({busy, redirect_valid}), 64'd0);

    check_eq("queues_empty", 64'(q_mepc.size() + q_mcause.size() + q_mtval.size() +
             q_mstatus.size() + q_redir.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
